// File: rtl/relu_maxpool_pkg.sv
// Shared definitions for the relu_maxpool post-processing stage:
// default widths, FSM state encoding and the signed max helper.
package relu_maxpool_pkg;

  localparam int DATA_SIZE = 32;
  localparam int ADDR_SIZE = 18;
  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WORK = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Two's-complement maximum; ties return a.
  function automatic logic [DATA_SIZE-1:0] smax(input logic [DATA_SIZE-1:0] a,
                                                input logic [DATA_SIZE-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

endpackage

// File: rtl/relu_maxpool_if.sv
// Command, pixel-stream and pooled-memory signals of relu_maxpool.
// The master drives commands and pixels; the slave (the pooling stage) drives memory writes.
interface relu_maxpool_if #(
  parameter int data_size    = relu_maxpool_pkg::DATA_SIZE,
  parameter int address_size = relu_maxpool_pkg::ADDR_SIZE
);
  logic                    cmd_start;
  logic [7:0]              mode_width;
  logic                    mode_relu;
  logic                    in_valid;
  logic [data_size-1:0]    in_data;
  logic                    wen;
  logic [address_size-1:0] paddr;
  logic [data_size-1:0]    pdata;
  logic                    cmd_done;
  logic                    cmd_done_valid;

  modport master (
    output cmd_start, mode_width, mode_relu, in_valid, in_data,
    input  wen, paddr, pdata, cmd_done, cmd_done_valid
  );

  modport slave (
    input  cmd_start, mode_width, mode_relu, in_valid, in_data,
    output wen, paddr, pdata, cmd_done, cmd_done_valid
  );
endinterface

// File: rtl/relu_maxpool_pool_line_buf.sv
// Half-width line buffer holding the horizontal pair maxima of an even row
// until the matching odd row arrives. Synchronous write, combinational read.
module pool_line_buf
  import relu_maxpool_pkg::*;
#(
  parameter int DEPTH = MAX_WIDTH / 2,
  parameter int DW    = DATA_SIZE,
  parameter int AW    = $clog2(MAX_WIDTH / 2)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end else begin
      mem_q[waddr_i] <= mem_q[waddr_i];
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/relu_maxpool.sv
// Optional ReLU followed by 2x2 stride-2 max-pooling of a W x W raster stream,
// writing the pooled map to sequential addresses and pulsing cmd_done per frame.
module relu_maxpool
  import relu_maxpool_pkg::*;
#(
  parameter int data_size    = DATA_SIZE,
  parameter int address_size = ADDR_SIZE,
  parameter int max_width    = MAX_WIDTH
) (
  input logic          clk,
  input logic          rst,
  relu_maxpool_if.slave bus
);

  localparam int LB_DEPTH = max_width / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  state_e                  state_q, state_d;
  logic [7:0]              w_q, w_d;
  logic [7:0]              col_q, col_d;
  logic [7:0]              row_q, row_d;
  logic                    relu_q, relu_d;
  logic [address_size-1:0] paddr_q, paddr_d;
  logic                    wen_q, wen_d;
  logic [data_size-1:0]    pdata_q, pdata_d;
  logic [data_size-1:0]    pair_q, pair_d;

  logic                    lb_we_s;
  logic [LB_AW-1:0]        lb_idx_s;
  logic [data_size-1:0]    lb_rdata_s;
  logic [data_size-1:0]    v_s;
  logic [data_size-1:0]    h_s;
  logic [data_size-1:0]    result_s;

  assign v_s      = (relu_q && bus.in_data[data_size-1]) ? {data_size{1'b0}} : bus.in_data;
  assign h_s      = smax(pair_q, v_s);
  assign result_s = smax(lb_rdata_s, h_s);
  assign lb_idx_s = col_q[LB_AW:1];

  pool_line_buf #(
    .DEPTH (LB_DEPTH),
    .DW    (data_size),
    .AW    (LB_AW)
  ) u_line_buf (
    .clk_i   (clk),
    .we_i    (lb_we_s),
    .waddr_i (lb_idx_s),
    .wdata_i (h_s),
    .raddr_i (lb_idx_s),
    .rdata_o (lb_rdata_s)
  );

  // Frame sequencing, raster counters and pooling decisions for the accepted beat.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    relu_d  = relu_q;
    col_d   = col_q;
    row_d   = row_q;
    pair_d  = pair_q;
    lb_we_s = 1'b0;
    wen_d   = 1'b0;
    pdata_d = {data_size{1'b0}};
    // paddr advances in the cycle after each write so the write sees the current index.
    paddr_d = wen_q ? (paddr_q + {{(address_size-1){1'b0}}, 1'b1}) : paddr_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_start) begin
          state_d = ST_WORK;
          w_d     = bus.mode_width;
          relu_d  = bus.mode_relu;
          col_d   = 8'd0;
          row_d   = 8'd0;
          paddr_d = {address_size{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WORK: begin
        if (w_q < 8'd2) begin
          state_d = ST_DONE;
        end else if (bus.in_valid) begin
          if (!col_q[0]) begin
            pair_d = v_s;
          end else if (!row_q[0]) begin
            lb_we_s = 1'b1;
          end else begin
            wen_d   = 1'b1;
            pdata_d = result_s;
          end
          if (col_q == (w_q - 8'd1)) begin
            col_d = 8'd0;
            row_d = row_q + 8'd1;
            state_d = (row_q == (w_q - 8'd1)) ? ST_DONE : ST_WORK;
          end else begin
            col_d = col_q + 8'd1;
          end
        end else begin
          state_d = ST_WORK;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      w_q     <= 8'd0;
      relu_q  <= 1'b0;
      col_q   <= 8'd0;
      row_q   <= 8'd0;
      pair_q  <= {data_size{1'b0}};
      paddr_q <= {address_size{1'b0}};
      wen_q   <= 1'b0;
      pdata_q <= {data_size{1'b0}};
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      relu_q  <= relu_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pair_q  <= pair_d;
      paddr_q <= paddr_d;
      wen_q   <= wen_d;
      pdata_q <= pdata_d;
    end
  end

  assign bus.wen            = wen_q;
  assign bus.paddr          = paddr_q;
  assign bus.pdata          = pdata_q;
  assign bus.cmd_done       = (state_q == ST_DONE);
  assign bus.cmd_done_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_relu_maxpool.sv
// Scoreboard bench for relu_maxpool: a frame-level pooling model fills an expected
// queue, and a negedge monitor checks every memory write and done pulse against it.
module tb_relu_maxpool;

  logic clk = 1'b0;
  logic rst = 1'b0;

  relu_maxpool_if bus ();

  relu_maxpool dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [17:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   pix_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  function automatic int pre(input int x, input bit relu);
    return (relu && x < 0) ? 0 : x;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reference: pooled map of pix_q as a W x W image, queued in output order.
  task automatic model(input int w, input bit relu);
    int h = w / 2;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < h; c++) begin
        int m;
        m = imax(imax(pre(pix_q[2*r*w + 2*c], relu), pre(pix_q[2*r*w + 2*c + 1], relu)),
                 imax(pre(pix_q[(2*r+1)*w + 2*c], relu), pre(pix_q[(2*r+1)*w + 2*c + 1], relu)));
        exp_q.push_back('{addr: 18'(r*h + c), data: 32'(m)});
      end
    end
  endtask

  // Monitor: every write must match the head of the queue; done must find it drained.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (bus.wen) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "spurious_wen", {14'd0, bus.paddr, bus.pdata}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk(bus.paddr == e.addr && bus.pdata == e.data, "pool_out",
              {14'd0, bus.paddr, bus.pdata}, {14'd0, e.addr, e.data});
        end
      end else begin
        chk(bus.pdata == 32'd0, "pdata_idle", 64'(bus.pdata), 64'd0);
      end
      if (bus.cmd_done || bus.cmd_done_valid) begin
        chk(bus.cmd_done == bus.cmd_done_valid, "done_valid_eq", 64'(bus.cmd_done_valid), 64'(bus.cmd_done));
        chk(exp_q.size() == 0, "done_drained", 64'(exp_q.size()), 64'd0);
      end
    end
  end

  task automatic fill_seq(input int n);
    pix_q.delete();
    for (int i = 0; i < n; i++) pix_q.push_back(i);
  endtask

  task automatic fill_const(input int n, input int v);
    pix_q.delete();
    for (int i = 0; i < n; i++) pix_q.push_back(v);
  endtask

  task automatic fill_rand(input int n);
    pix_q.delete();
    for (int i = 0; i < n; i++) pix_q.push_back(int'($urandom));
  endtask

  task automatic start(input int w, input bit relu);
    bus.cmd_start  = 1'b1;
    bus.mode_width = 8'(w);
    bus.mode_relu  = relu;
    @(posedge clk); #1;
    bus.cmd_start  = 1'b0;
  endtask

  // gap_mode: 0 none, 1 idle cycle before every odd beat, 2 random gaps.
  task automatic run_frame(input int w, input bit relu, input int gap_mode, input int start_at);
    model(w, relu);
    start(w, relu);
    for (int i = 0; i < w*w; i++) begin
      int gaps;
      gaps = (gap_mode == 1) ? (i % 2) :
             (gap_mode == 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      repeat (gaps) begin
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = pix_q[i];
      if (i == start_at) begin
        bus.cmd_start  = 1'b1;
        bus.mode_width = 8'd2;
        bus.mode_relu  = ~relu;
      end
      @(posedge clk); #1;
      bus.cmd_start = 1'b0;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk(bus.cmd_done == 1'b1, "done_timing", 64'(bus.cmd_done), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk(bus.cmd_done == 1'b0, "done_one_cycle", 64'(bus.cmd_done), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_tiny(input int w);
    start(w, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h1234_5678;
    @(negedge clk);
    chk(bus.cmd_done == 1'b0, "tiny_done_early", 64'(bus.cmd_done), 64'd0);
    @(negedge clk);
    chk(bus.cmd_done == 1'b1, "tiny_done", 64'(bus.cmd_done), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk(bus.cmd_done == 1'b0, "tiny_done_clear", 64'(bus.cmd_done), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_start  = 1'b0;
    bus.mode_width = 8'd0;
    bus.mode_relu  = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = 32'd0;
    rst            = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(bus.wen == 1'b0, "rst_wen", 64'(bus.wen), 64'd0);
    chk(bus.paddr == 18'd0, "rst_paddr", 64'(bus.paddr), 64'd0);
    chk(bus.pdata == 32'd0, "rst_pdata", 64'(bus.pdata), 64'd0);
    chk(bus.cmd_done == 1'b0, "rst_done", 64'(bus.cmd_done), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed frames.
    fill_seq(16);               run_frame(4, 1'b0, 0, -1);
    fill_const(16, 32'hFFFF_FFFB); run_frame(4, 1'b1, 0, -1);
    fill_const(16, 32'hFFFF_FFFB); run_frame(4, 1'b0, 0, -1);
    fill_seq(25);               run_frame(5, 1'b0, 0, -1);
    fill_seq(16);               run_frame(4, 1'b0, 1, -1);

    // Reset after six beats: the sixth beat completes the first 2x2 window.
    fill_seq(16);
    start(4, 1'b0);
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = pix_q[i];
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    exp_q.push_back('{addr: 18'd0, data: 32'd5});
    @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk(bus.wen == 1'b0, "midrst_wen", 64'(bus.wen), 64'd0);
    chk(bus.paddr == 18'd0, "midrst_paddr", 64'(bus.paddr), 64'd0);
    chk(bus.pdata == 32'd0, "midrst_pdata", 64'(bus.pdata), 64'd0);
    chk(bus.cmd_done == 1'b0, "midrst_done", 64'(bus.cmd_done), 64'd0);
    @(posedge clk); #1;
    fill_seq(16); run_frame(4, 1'b0, 0, -1);

    // Degenerate widths and an ignored mid-frame start.
    run_tiny(1);
    run_tiny(0);
    fill_seq(16); run_frame(4, 1'b0, 0, 7);

    // Randomized frames, including the largest supported width.
    for (int k = 0; k < 8; k++) begin
      int w;
      w = int'($urandom_range(2, 16));
      fill_rand(w*w);
      run_frame(w, 1'($urandom_range(0, 1)), 2, -1);
    end
    fill_rand(64*64); run_frame(64, 1'b1, 0, -1);
    fill_rand(63*63); run_frame(63, 1'b0, 2, -1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(exp_q.size() == 0, "queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
